// File: rtl/s2mm_burst_ctrl_pkg.sv
// rtl/s2mm_burst_ctrl_pkg.sv - shared FSM state type and AXI constants for the S2MM burst controller
package s2mm_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int         BOUNDARY_4K   = 4096;

endpackage

// File: rtl/s2mm_burst_len.sv
// rtl/s2mm_burst_len.sv - burst size = min(MAX_BURST_LEN, beats to buffer end, beats to next 4 KB boundary)
module s2mm_burst_len
  import s2mm_burst_ctrl_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic [MM_ADDR_WIDTH-1:0] addr,
  input  logic [4:0]               log_length,
  output logic [8:0]               burst_beats
);

  localparam int BYTES_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int AW1 = MM_ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] ONE = AW1'(1);

  logic [AW1-1:0] buf_beats;
  logic [AW1-1:0] beat_off;
  logic [AW1-1:0] to_end;
  logic [12:0]    to_4k;

  // One spare bit so a 2^31-beat buffer still fits without wrapping.
  assign buf_beats = ONE << log_length;
  assign beat_off  = {1'b0, (addr >> BYTES_LOG2)} & (buf_beats - ONE);
  assign to_end    = buf_beats - beat_off;
  assign to_4k     = (13'(BOUNDARY_4K) - {1'b0, addr[11:0]}) >> BYTES_LOG2;

  always_comb begin
    burst_beats = 9'(MAX_BURST_LEN);
    if (to_end < AW1'(burst_beats)) burst_beats = to_end[8:0];
    if (to_4k < 13'(burst_beats))   burst_beats = to_4k[8:0];
  end

endmodule

// File: rtl/s2mm_burst_ctrl.sv
// rtl/s2mm_burst_ctrl.sv - AXI4 S2MM burst sequencer; partial-burst timeout under S2MM_BURST_CTRL_TIMEOUT_EN
module s2mm_burst_ctrl
  import s2mm_burst_ctrl_pkg::*;
#(
  parameter int MM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST_LEN = 16
`ifdef S2MM_BURST_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic [4:0]               log_length,
  input  logic [MM_ADDR_WIDTH-1:0] write_buffer,
  input  logic [8:0]               fifo_count,
  input  logic                     fifo_valid,
  output logic                     fifo_ready,
  output logic [MM_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  output logic                     m_axi_wlast,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready,
  output logic                     writing,
  output logic                     idle,
  output logic                     error
);

  state_t     state;
  logic [7:0] beat_cnt;
  logic [8:0] burst_beats;
  logic [8:0] issue_beats;
  logic       full_ok;
  logic       issue;
  logic       in_data;
  logic       w_hs;

  s2mm_burst_len #(
    .MM_ADDR_WIDTH (MM_ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .MAX_BURST_LEN (MAX_BURST_LEN)
  ) u_len (
    .addr        (write_buffer),
    .log_length  (log_length),
    .burst_beats (burst_beats)
  );

  assign full_ok = enable && (fifo_count >= burst_beats);

`ifdef S2MM_BURST_CTRL_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;
  logic            partial;
  logic            to_hit;

  assign partial     = enable && (fifo_count != 9'd0) && (fifo_count < burst_beats);
  assign to_hit      = partial && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign issue       = (state == ST_IDLE) && (full_ok || to_hit);
  assign issue_beats = full_ok ? burst_beats : fifo_count;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                                to_cnt <= '0;
    else if (issue || fifo_count == 9'd0)      to_cnt <= '0;
    else if (state == ST_IDLE && partial)      to_cnt <= to_cnt + TO_W'(1);
  end
`else
  assign issue       = (state == ST_IDLE) && full_ok;
  assign issue_beats = burst_beats;
`endif

  // W stays gated until the address phase has been accepted.
  assign in_data      = (state == ST_DATA);
  assign m_axi_wvalid = in_data && fifo_valid;
  assign fifo_ready   = in_data && m_axi_wready;
  assign w_hs         = m_axi_wvalid && m_axi_wready;
  assign writing      = w_hs;
  assign m_axi_wlast  = in_data && (beat_cnt == m_axi_awlen);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_bready  <= 1'b0;
      idle          <= 1'b1;
      error         <= 1'b0;
      beat_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            m_axi_awaddr  <= write_buffer;
            m_axi_awlen   <= 8'(issue_beats - 9'd1);
            m_axi_awvalid <= 1'b1;
            idle          <= 1'b0;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (m_axi_awready) begin
            m_axi_awvalid <= 1'b0;
            beat_cnt      <= '0;
            state         <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            if (beat_cnt == m_axi_awlen) begin
              m_axi_bready <= 1'b1;
              state        <= ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            error        <= error | (m_axi_bresp != AXI_RESP_OKAY);
            idle         <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s2mm_burst_ctrl.sv
// tb/tb_s2mm_burst_ctrl.sv - directed self-checking bench for s2mm_burst_ctrl
module tb_s2mm_burst_ctrl;

  logic        aclk = 1'b0;
  logic        areset = 1'b0;
  logic        enable = 1'b0;
  logic [4:0]  log_length = 5'd0;
  logic [31:0] write_buffer = 32'd0;
  logic [8:0]  fifo_count = 9'd0;
  logic        fifo_valid = 1'b0;
  logic        fifo_ready;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic        m_axi_wlast;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;
  logic        writing;
  logic        idle;
  logic        error;

  int tests = 0;
  int fails = 0;

  s2mm_burst_ctrl dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .log_length    (log_length),
    .write_buffer  (write_buffer),
    .fifo_count    (fifo_count),
    .fifo_valid    (fifo_valid),
    .fifo_ready    (fifo_ready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .writing       (writing),
    .idle          (idle),
    .error         (error)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plays the AXI slave for one burst; returns cycles from entry until awvalid.
  task automatic run_burst(input string tag, input logic [31:0] exp_addr, input int exp_len,
                           input logic [1:0] resp, input int aw_delay, input bit stall,
                           output int lat);
    int pulses;
    lat = 0;
    while (m_axi_awvalid !== 1'b1 && lat < 100) begin
      @(negedge aclk); #1;
      lat++;
    end
    check({tag, " awvalid"}, 32'(m_axi_awvalid), 32'd1);
    check({tag, " awaddr"}, m_axi_awaddr, exp_addr);
    check({tag, " awlen"}, 32'(m_axi_awlen), 32'(exp_len));
    fifo_valid   = 1'b1;
    m_axi_wready = 1'b1;
    #1;
    check({tag, " wvalid gated"}, 32'(m_axi_wvalid), 32'd0);
    check({tag, " writing gated"}, 32'(writing), 32'd0);
    for (int i = 0; i < aw_delay; i++) begin
      @(negedge aclk);
      write_buffer = 32'hDEAD_BEE0;
      log_length   = 5'd2;
      #1;
      check({tag, " hold awvalid"}, 32'(m_axi_awvalid), 32'd1);
      check({tag, " hold awaddr"}, m_axi_awaddr, exp_addr);
      check({tag, " hold awlen"}, 32'(m_axi_awlen), 32'(exp_len));
    end
    @(negedge aclk);
    m_axi_awready = 1'b1;
    #1;
    @(negedge aclk);
    m_axi_awready = 1'b0;
    #1;
    check({tag, " awvalid drop"}, 32'(m_axi_awvalid), 32'd0);
    pulses = 0;
    for (int b = 0; b <= exp_len; b++) begin
      if (stall && b == 1) begin
        fifo_valid = 1'b0;
        #1;
        check({tag, " stall writing"}, 32'(writing), 32'd0);
        @(negedge aclk);
        fifo_valid = 1'b1;
        #1;
      end
      check({tag, " writing"}, 32'(writing), 32'd1);
      check({tag, " wlast"}, 32'(m_axi_wlast), 32'(b == exp_len));
      if (writing === 1'b1) pulses++;
      @(negedge aclk); #1;
    end
    fifo_valid   = 1'b0;
    m_axi_wready = 1'b0;
    #1;
    check({tag, " pulses"}, 32'(pulses), 32'(exp_len + 1));
    check({tag, " bready"}, 32'(m_axi_bready), 32'd1);
    check({tag, " not idle"}, 32'(idle), 32'd0);
    m_axi_bvalid = 1'b1;
    m_axi_bresp  = resp;
    enable       = 1'b0;
    @(negedge aclk);
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    #1;
    check({tag, " idle after B"}, 32'(idle), 32'd1);
    check({tag, " bready drop"}, 32'(m_axi_bready), 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    areset       = 1'b1;
    fifo_valid   = 1'b1;
    m_axi_wready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    check("rst awvalid", 32'(m_axi_awvalid), 32'd0);
    check("rst wvalid", 32'(m_axi_wvalid), 32'd0);
    check("rst fifo_ready", 32'(fifo_ready), 32'd0);
    check("rst bready", 32'(m_axi_bready), 32'd0);
    check("rst idle", 32'(idle), 32'd1);
    check("rst error", 32'(error), 32'd0);
    check("rst wlast", 32'(m_axi_wlast), 32'd0);
    check("rst awaddr", m_axi_awaddr, 32'd0);

    @(negedge aclk);
    areset       = 1'b0;
    fifo_valid   = 1'b0;
    m_axi_wready = 1'b0;
    log_length   = 5'd8;
    write_buffer = 32'h1000_0000;
    fifo_count   = 9'd16;
    repeat (5) @(negedge aclk);
    #1;
    check("disabled no awvalid", 32'(m_axi_awvalid), 32'd0);
    enable = 1'b1;
    run_burst("t1", 32'h1000_0000, 15, 2'b00, 0, 1'b0, lat);
    check("t1 issue latency", 32'(lat), 32'd1);
    check("t1 error", 32'(error), 32'd0);

    log_length   = 5'd3;
    write_buffer = 32'h1000_0014;
    fifo_count   = 9'd3;
    enable       = 1'b1;
    run_burst("t2", 32'h1000_0014, 2, 2'b00, 0, 1'b1, lat);
    write_buffer = 32'h1000_0020;
    fifo_count   = 9'd8;
    enable       = 1'b1;
    run_burst("t2b", 32'h1000_0020, 7, 2'b00, 0, 1'b0, lat);

    log_length   = 5'd12;
    write_buffer = 32'h1000_0FF0;
    fifo_count   = 9'd16;
    enable       = 1'b1;
    run_burst("t3", 32'h1000_0FF0, 3, 2'b00, 0, 1'b0, lat);
    write_buffer = 32'h1000_1000;
    enable       = 1'b1;
    run_burst("t3b", 32'h1000_1000, 15, 2'b00, 0, 1'b0, lat);

    log_length   = 5'd8;
    write_buffer = 32'h1000_0100;
    fifo_count   = 9'd40;
    enable       = 1'b1;
    run_burst("t5", 32'h1000_0100, 15, 2'b10, 10, 1'b0, lat);
    check("t5 error set", 32'(error), 32'd1);
    log_length   = 5'd8;
    write_buffer = 32'h1000_0140;
    fifo_count   = 9'd16;
    enable       = 1'b1;
    run_burst("t5b", 32'h1000_0140, 15, 2'b00, 0, 1'b0, lat);
    check("t5b error sticky", 32'(error), 32'd1);

    log_length   = 5'd8;
    write_buffer = 32'h1000_0000;
    fifo_count   = 9'd15;
    enable       = 1'b1;
`ifdef S2MM_BURST_CTRL_TIMEOUT_EN
    run_burst("t4", 32'h1000_0000, 14, 2'b00, 0, 1'b0, lat);
`else
    seen = 0;
    repeat (1000) begin
      @(negedge aclk); #1;
      if (m_axi_awvalid !== 1'b0) seen++;
    end
    check("t4 partial waits", 32'(seen), 32'd0);
    check("t4 idle", 32'(idle), 32'd1);
    enable = 1'b0;
`endif

    @(negedge aclk);
    fifo_count = 9'd16;
    enable     = 1'b1;
    lat = 0;
    while (m_axi_awvalid !== 1'b1 && lat < 100) begin
      @(negedge aclk); #1;
      lat++;
    end
    check("t6 awvalid", 32'(m_axi_awvalid), 32'd1);
    m_axi_awready = 1'b1;
    @(negedge aclk);
    m_axi_awready = 1'b0;
    fifo_valid    = 1'b1;
    m_axi_wready  = 1'b1;
    repeat (3) @(negedge aclk);
    areset = 1'b1;
    #1;
    check("t6 rst awvalid", 32'(m_axi_awvalid), 32'd0);
    check("t6 rst wvalid", 32'(m_axi_wvalid), 32'd0);
    check("t6 rst writing", 32'(writing), 32'd0);
    check("t6 rst bready", 32'(m_axi_bready), 32'd0);
    check("t6 rst idle", 32'(idle), 32'd1);
    check("t6 rst error", 32'(error), 32'd0);
    @(negedge aclk);
    areset       = 1'b0;
    fifo_valid   = 1'b0;
    m_axi_wready = 1'b0;
    run_burst("t7", 32'h1000_0000, 15, 2'b00, 0, 1'b0, lat);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", tests);
    $fatal(1);
  end

endmodule
